pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Program-counter register and fetch sequencer; consumes PCSrc from the branch comparator.
//  Holds PC, requests instructions from imem with a req/ready handshake, and presents one
//  instruction per EXEC window. Selects next PC (PC+4 or target) when the instruction retires.
//  Counts retired instructions. Sits at the head of the RV32I datapath, upstream of decode.
// PARAMETERS
//  N             32            datapath / PC width
//  RESET_VECTOR  32'h0000_0000 PC value loaded on reset
//  CNT_W         64            width of retire counter
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  PCSrc        in   2      next-PC select: 00 PC+4, 01 target, 10 target&~1 (JALR), 11 = PC+4
//  PCTarget     in   N      branch/jump target from the adder/ALU, valid in EXEC
//  stall        in   1      hold current instruction in EXEC (downstream not done)
//  imem_ready   in   1      imem returns instruction for imem_addr this cycle
//  imem_req     out  1      fetch request
//  imem_addr    out  N      fetch address (= PC)
//  instr_valid  out  1      fetched instruction is live; datapath may use PCSrc/PCTarget
//  PC           out  N      current PC register
//  PCPlus4      out  N      PC + 4, mod 2^N (for JAL/JALR link)
//  retire_cnt   out  CNT_W  instructions retired since reset
//  trap         out  1      misaligned-target trap taken (see CONFIGURATION)
//  trap_addr    out  N      offending target address, valid while trap=1
// BEHAVIOUR
//  Reset (reset=1 at a rising edge): state<=IDLE, PC<=RESET_VECTOR, retire_cnt<=0,
//   trap<=0, trap_addr<=0. Outputs in IDLE: imem_req=0, instr_valid=0. Reset wins over
//   everything, in any state, including mid-handshake; an imem_ready in that cycle is ignored.
//  States (2-bit): IDLE, FETCH, EXEC, TRAP. imem_addr=PC always; imem_req=(state==FETCH);
//   instr_valid=(state==EXEC); trap=(state==TRAP).
//  IDLE  -> FETCH unconditionally next cycle.
//  FETCH -> EXEC when imem_ready=1; else stay. PC held. Min fetch latency 1 cycle.
//  EXEC, stall=1: stay; PC, retire_cnt held; PCSrc ignored.
//  EXEC, stall=0: next = select(PCSrc). PC<=next; retire_cnt<=retire_cnt+1 (wraps at 2^CNT_W);
//   -> FETCH. Exactly one retire per EXEC exit. Steady state is 2 cycles/instruction
//   when imem_ready is tied high.
//  Next-PC arithmetic: PC+4 and target are both N bits, wrapping mod 2^N. For example,
//   PC=FFFF_FFFC with PCSrc=00 gives next=0000_0000. PCSrc=10 clears bit0 of PCTarget.
//  Misaligned target: next[1:0]!=0. Handling depends on the macro.
//  TRAP: sticky; imem_req=0, instr_valid=0, PC and retire_cnt frozen; exit only via reset.
//  imem_ready outside FETCH is ignored.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined:
//   - Misaligned next in EXEC (stall=0): state<=TRAP, trap_addr<=next.
//   - PC is not updated and retire_cnt is not incremented.
//  PC_MISALIGN_TRAP_EN undefined:
//   - next[1:0] is forced to 00 and execution continues.
//   - TRAP is unreachable; trap=0 and trap_addr=0 constantly.
// TESTING
//  1 reset, imem_ready=1, stall=0, PCSrc=00 x3 -> imem_addr 0,4,8 on FETCH cycles; retire_cnt=3
//  2 EXEC PC=0x10, PCSrc=01, PCTarget=0x40 -> next FETCH imem_addr=0x40, PCPlus4 was 0x14
//  3 EXEC held 3 cycles stall=1 with PCSrc=01 toggling -> PC stays 0x8, no retire; stall=0 retires once
//  4 FETCH imem_ready=0 for 5 cycles -> imem_req high, PC constant; ready=1 -> EXEC next cycle
//  5 PC=FFFF_FFFC, PCSrc=00 -> PC=0000_0000; PCSrc=10, target=0x101 -> PC=0x100
//  6 PCTarget=0x22 PCSrc=01: EN -> trap=1, trap_addr=0x22, req=0 until reset; !EN -> PC=0x20
//  7 reset asserted in FETCH with imem_ready=1 -> IDLE, PC=RESET_VECTOR, retire_cnt=0

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer at the head of the RV32I datapath.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap on misaligned next-PC instead of forcing alignment.
module pc_fetch_ctrl #(
  parameter int             N            = 32,
  parameter logic [N-1:0]   RESET_VECTOR = '0,
  parameter int             CNT_W        = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       PCSrc,
  input  logic [N-1:0]     PCTarget,
  input  logic             stall,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [N-1:0]     imem_addr,
  output logic             instr_valid,
  output logic [N-1:0]     PC,
  output logic [N-1:0]     PCPlus4,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             trap,
  output logic [N-1:0]     trap_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    TRAP  = 2'b11
  } state_t;

  localparam logic [N-1:0]     FOUR      = {{(N-3){1'b0}}, 3'd4};
  localparam logic [N-1:0]     LOW2_MASK = {{(N-2){1'b0}}, 2'b11};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [N-1:0]     pc_q, pc_nxt;
  logic [N-1:0]     pc_plus4;
  logic [N-1:0]     sel_pc;
  logic [N-1:0]     aligned_pc;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  assign pc_plus4   = pc_q + FOUR;
  assign aligned_pc = sel_pc & ~LOW2_MASK;

  // PCSrc=11 is treated like 00 so an undefined encoding still makes forward progress.
  always_comb begin
    sel_pc = pc_plus4;
    case (PCSrc)
      2'b01:   sel_pc = PCTarget;
      2'b10:   sel_pc = PCTarget & ~{{(N-1){1'b0}}, 1'b1};
      default: sel_pc = pc_plus4;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic [N-1:0] taddr_q, taddr_nxt;
  logic         misaligned;

  assign misaligned = |sel_pc[1:0];
  assign trap_addr  = taddr_q;
`else
  assign trap_addr  = '0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
    taddr_nxt = taddr_q;
`endif
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: if (imem_ready) state_nxt = EXEC;
      EXEC: begin
        if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
          // A faulting instruction does not retire and leaves PC pointing at itself.
          if (misaligned) begin
            state_nxt = TRAP;
            taddr_nxt = sel_pc;
          end else begin
            pc_nxt    = aligned_pc;
            cnt_nxt   = cnt_q + CNT_ONE;
            state_nxt = FETCH;
          end
`else
          pc_nxt    = aligned_pc;
          cnt_nxt   = cnt_q + CNT_ONE;
          state_nxt = FETCH;
`endif
        end
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      taddr_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
`ifdef PC_MISALIGN_TRAP_EN
      taddr_q <= taddr_nxt;
`endif
    end
  end

  assign PC          = pc_q;
  assign imem_addr   = pc_q;
  assign PCPlus4     = pc_plus4;
  assign retire_cnt  = cnt_q;
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign trap        = (state == TRAP);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed vector table, hand-written corner sequences,
// and randomized cycles checked against a transaction-level reference model.
module tb_pc_fetch_ctrl;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget;
  logic        stall;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [63:0] retire_cnt;
  logic        trap;
  logic [31:0] trap_addr;

  int testsRun = 0;
  int testsFailed = 0;

  pc_fetch_ctrl #(.N(32), .RESET_VECTOR(32'h0000_0000), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .instr_valid(instr_valid), .PC(PC), .PCPlus4(PCPlus4), .retire_cnt(retire_cnt),
    .trap(trap), .trap_addr(trap_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the fetcher is doing, described as a few flags and plain arithmetic.
  bit          mFetching, mExecuting, mTrapped;
  longint      mPc;
  longint      mCnt;
  longint      mTrapAddr;

  task automatic modelUpdate(input logic r, input logic [1:0] s, input logic [31:0] t,
                             input logic st, input logic rd);
    longint nxt;
    longint tgt;
    tgt = longint'(t);
    if (r) begin
      mFetching = 0; mExecuting = 0; mTrapped = 0;
      mPc = 0; mCnt = 0; mTrapAddr = 0;
    end else if (mTrapped) begin
      // sticky until reset
    end else if (mFetching) begin
      if (rd) begin mFetching = 0; mExecuting = 1; end
    end else if (mExecuting) begin
      if (!st) begin
        if (s == 2'd1)      nxt = tgt;
        else if (s == 2'd2) nxt = tgt - (tgt % 2);
        else                nxt = (mPc + 4) % 64'h1_0000_0000;
        if ((nxt % 4) != 0 && TRAP_EN) begin
          mExecuting = 0; mTrapped = 1; mTrapAddr = nxt;
        end else begin
          mPc = nxt - (nxt % 4);
          mCnt = mCnt + 1;
          mExecuting = 0; mFetching = 1;
        end
      end
    end else begin
      mFetching = 1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] s, input logic [31:0] t,
                               input logic st, input logic rd);
    reset = r; PCSrc = s; PCTarget = t; stall = st; imem_ready = rd;
    @(posedge clk);
    modelUpdate(r, s, t, st, rd);
    #1;
  endtask

  task automatic cyc(input logic [1:0] s, input logic [31:0] t, input logic st, input logic rd);
    applyStimulus(1'b0, s, t, st, rd);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic eReq, input logic eValid,
                          input logic [31:0] ePc, input logic [63:0] eCnt,
                          input logic eTrap, input logic [31:0] eTaddr);
    logic [31:0] eP4;
    eP4 = ePc + 32'd4;
    checkOutput({tag, ".imem_req"},    64'(imem_req),    64'(eReq));
    checkOutput({tag, ".instr_valid"}, 64'(instr_valid), 64'(eValid));
    checkOutput({tag, ".PC"},          64'(PC),          64'(ePc));
    checkOutput({tag, ".imem_addr"},   64'(imem_addr),   64'(ePc));
    checkOutput({tag, ".PCPlus4"},     64'(PCPlus4),     64'(eP4));
    checkOutput({tag, ".retire_cnt"},  retire_cnt,       eCnt);
    checkOutput({tag, ".trap"},        64'(trap),        64'(eTrap));
    checkOutput({tag, ".trap_addr"},   64'(trap_addr),   64'(eTaddr));
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic        stl;
    logic        rdy;
    logic        eReq;
    logic        eValid;
    logic [31:0] ePc;
    logic [63:0] eCnt;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input logic rst, input logic [1:0] src, input logic [31:0] tgt,
                        input logic stl, input logic rdy, input logic eReq, input logic eValid,
                        input logic [31:0] ePc, input logic [63:0] eCnt);
    vec_t v;
    v.rst = rst; v.src = src; v.tgt = tgt; v.stl = stl; v.rdy = rdy;
    v.eReq = eReq; v.eValid = eValid; v.ePc = ePc; v.eCnt = eCnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] rt;
    logic        rr, rst_r, rd_r;

    reset = 1'b1; PCSrc = 2'b00; PCTarget = '0; stall = 1'b0; imem_ready = 1'b0;

    // Sequential PC+4 fetches, a stalled EXEC, a slow imem, then a taken jump.
    addRow(1, 2'b00, 32'h0,  0, 1, 0, 0, 32'h00, 0);
    addRow(0, 2'b00, 32'h0,  0, 1, 1, 0, 32'h00, 0);
    addRow(0, 2'b00, 32'h0,  0, 1, 0, 1, 32'h00, 0);
    addRow(0, 2'b00, 32'h0,  0, 1, 1, 0, 32'h04, 1);
    addRow(0, 2'b00, 32'h0,  0, 1, 0, 1, 32'h04, 1);
    addRow(0, 2'b00, 32'h0,  0, 1, 1, 0, 32'h08, 2);
    addRow(0, 2'b00, 32'h0,  0, 1, 0, 1, 32'h08, 2);
    addRow(0, 2'b01, 32'h40, 1, 1, 0, 1, 32'h08, 2);
    addRow(0, 2'b00, 32'h40, 1, 1, 0, 1, 32'h08, 2);
    addRow(0, 2'b01, 32'h40, 1, 1, 0, 1, 32'h08, 2);
    addRow(0, 2'b00, 32'h40, 0, 1, 1, 0, 32'h0C, 3);
    for (int i = 0; i < 5; i++) addRow(0, 2'b01, 32'h80, 0, 0, 1, 0, 32'h0C, 3);
    addRow(0, 2'b00, 32'h0,  0, 1, 0, 1, 32'h0C, 3);
    addRow(0, 2'b01, 32'h10, 0, 1, 1, 0, 32'h10, 4);
    addRow(0, 2'b00, 32'h0,  0, 1, 0, 1, 32'h10, 4);
    addRow(0, 2'b01, 32'h40, 0, 1, 1, 0, 32'h40, 5);
    addRow(0, 2'b00, 32'h0,  0, 1, 0, 1, 32'h40, 5);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].src, vecs[i].tgt, vecs[i].stl, vecs[i].rdy);
      checkAll($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eValid, vecs[i].ePc,
               vecs[i].eCnt, 1'b0, 32'h0);
    end

    // PC wraparound and JALR bit-0 clearing.
    applyStimulus(1, 2'b00, 32'h0, 0, 1);
    cyc(2'b00, 32'h0, 0, 1);
    cyc(2'b00, 32'h0, 0, 1);
    cyc(2'b01, 32'hFFFF_FFFC, 0, 1);
    checkAll("wrap_fetch", 1, 0, 32'hFFFF_FFFC, 1, 0, 0);
    cyc(2'b00, 32'h0, 0, 1);
    checkAll("wrap_exec", 0, 1, 32'hFFFF_FFFC, 1, 0, 0);
    cyc(2'b00, 32'h0, 0, 1);
    checkAll("wrap_zero", 1, 0, 32'h0, 2, 0, 0);
    cyc(2'b00, 32'h0, 0, 1);
    cyc(2'b10, 32'h101, 0, 1);
    checkAll("jalr_clear", 1, 0, 32'h100, 3, 0, 0);
    cyc(2'b00, 32'h0, 0, 1);

    // Misaligned target.
    cyc(2'b01, 32'h22, 0, 1);
`ifdef PC_MISALIGN_TRAP_EN
    checkAll("misalign_trap", 0, 0, 32'h100, 3, 1, 32'h22);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 32'h44, 0, 1);
      checkAll($sformatf("trap_sticky%0d", i), 0, 0, 32'h100, 3, 1, 32'h22);
    end
`else
    checkAll("misalign_force", 1, 0, 32'h20, 4, 0, 0);
`endif

    // Reset mid-handshake with imem_ready high must land in IDLE.
    applyStimulus(1, 2'b00, 32'h0, 0, 1);
    cyc(2'b00, 32'h0, 0, 1);
    cyc(2'b00, 32'h0, 0, 1);
    cyc(2'b01, 32'h80, 0, 1);
    checkAll("pre_reset", 1, 0, 32'h80, 1, 0, 0);
    applyStimulus(1, 2'b00, 32'h0, 0, 1);
    checkAll("reset_in_fetch", 0, 0, 32'h0, 0, 0, 0);
    cyc(2'b00, 32'h0, 0, 1);
    checkAll("after_reset", 1, 0, 32'h0, 0, 0, 0);

    // Randomized cycles against the reference model.
    applyStimulus(1, 2'b00, 32'h0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      rst_r = ($urandom_range(0, 39) == 0);
      rs    = 2'($urandom_range(0, 3));
      rt    = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) rt = 32'hFFFF_FFFC;
      rr    = ($urandom_range(0, 3) == 0);
      rd_r  = ($urandom_range(0, 2) != 0);
      applyStimulus(rst_r, rs, rt, rr, rd_r);
      checkAll($sformatf("rand%0d", i), mFetching, mExecuting, 32'(mPc), 64'(mCnt),
               mTrapped, 32'(mTrapAddr));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
